// File: rtl/fifo_ser_tx.sv
// fifo_ser_tx
// Read-side consumer for the dual-clock FIFO. Pops one word whenever the FIFO
// is non-empty and the transmitter is idle, then sends it as an asynchronous
// serial frame: start bit (0), DW data bits LSB first, stop bit (1). Each bit
// lasts DIV clocks of rclk.
//
// Ports:
//   rclk          read-domain clock
//   rst_i         asynchronous active-high reset
//   fifo_dat_i    FIFO head word (show-ahead)
//   fifo_empty_i  FIFO empty flag
//   fifo_ren_o    FIFO read enable (combinational)
//   tx_o          serial line, registered, idles high
//   busy_o        high while a frame is in progress
//   done_o        one-clock pulse on the final stop-bit clock
//
// state | meaning
// IDLE  | line high, waiting for a FIFO word
// START | driving start bit (0)
// DATA  | driving data bits, LSB first
// STOP  | driving stop bit (1)

module fifo_ser_tx #(
    parameter int DW  = 4,
    parameter int DIV = 8
) (
    input  logic          rclk,
    input  logic          rst_i,
    input  logic [DW-1:0] fifo_dat_i,
    input  logic          fifo_empty_i,
    output logic          fifo_ren_o,
    output logic          tx_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] shreg, shreg_nxt, shreg_shr;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic          tx_nxt;
    logic          baud_last;
    logic          ren, done;

    // Logical shift keeps DW=1 legal: the next bit after the shift is shreg_shr[0].
    assign shreg_shr = shreg >> 1;
    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        tx_nxt    = tx_o;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        ren       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty_i) begin
                    ren       = 1'b1;
                    shreg_nxt = fifo_dat_i;
                    tx_nxt    = 1'b0;
                    baud_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_last) begin
                    tx_nxt    = shreg[0];
                    bit_nxt   = '0;
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shreg_nxt = shreg_shr;
                        tx_nxt    = shreg_shr[0];
                        bit_nxt   = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    done      = 1'b1;
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            shreg    <= '0;
            tx_o     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            tx_o     <= tx_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
        end
    end

    assign fifo_ren_o = ren;
    assign done_o     = done;
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_fifo_ser_tx.sv
// tb_fifo_ser_tx
// Directed bench for fifo_ser_tx. Two instances share rclk/rst_i:
//   dut_a: DW=4, DIV=8 (main frames, back-to-back, mid-frame arrival, reset)
//   dut_b: DW=1, DIV=2 (minimum-size frames)
// Each instance reads from a small show-ahead FIFO model. Outputs are sampled
// on the falling edge; k counts cycles after the pop edge.

module tb_fifo_ser_tx;

    logic rclk;
    logic rst_i;

    // FIFO model A
    logic [3:0] a_mem [16];
    int         a_wp = 0;
    int         a_rp = 0;
    logic [3:0] a_dat;
    logic       a_empty;
    logic       a_ren, a_tx, a_busy, a_done;

    // FIFO model B
    logic       b_mem [16];
    int         b_wp = 0;
    int         b_rp = 0;
    logic       b_dat;
    logic       b_empty;
    logic       b_ren, b_tx, b_busy, b_done;

    int passed = 0;
    int total  = 0;

    assign a_empty = (a_wp == a_rp);
    assign a_dat   = a_mem[a_rp];
    assign b_empty = (b_wp == b_rp);
    assign b_dat   = b_mem[b_rp];

    always @(posedge rclk) if (a_ren) a_rp <= a_rp + 1;
    always @(posedge rclk) if (b_ren) b_rp <= b_rp + 1;

    fifo_ser_tx #(.DW(4), .DIV(8)) dut_a (
        .rclk         (rclk),
        .rst_i        (rst_i),
        .fifo_dat_i   (a_dat),
        .fifo_empty_i (a_empty),
        .fifo_ren_o   (a_ren),
        .tx_o         (a_tx),
        .busy_o       (a_busy),
        .done_o       (a_done)
    );

    fifo_ser_tx #(.DW(1), .DIV(2)) dut_b (
        .rclk         (rclk),
        .rst_i        (rst_i),
        .fifo_dat_i   (b_dat),
        .fifo_empty_i (b_empty),
        .fifo_ren_o   (b_ren),
        .tx_o         (b_tx),
        .busy_o       (b_busy),
        .done_o       (b_done)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic push_a(input logic [3:0] w);
        a_mem[a_wp] = w;
        a_wp++;
    endtask

    task automatic push_b(input logic w);
        b_mem[b_wp] = w;
        b_wp++;
    endtask

    task automatic idle_a(input string tag, input logic exp_ren);
        check($sformatf("%s idle tx", tag), a_tx, 1'b1);
        check($sformatf("%s idle busy", tag), a_busy, 1'b0);
        check($sformatf("%s idle done", tag), a_done, 1'b0);
        check($sformatf("%s idle ren", tag), a_ren, exp_ren);
    endtask

    // Called one half-cycle before the pop edge; ends at k=47.
    // If push_k >= 0, push_w is written into the FIFO at that cycle.
    task automatic frame_a(input logic [3:0] w, input int push_k,
                           input logic [3:0] push_w, input string tag);
        logic exp_tx;
        for (int k = 0; k < 48; k++) begin
            @(negedge rclk);
            if (k < 8)       exp_tx = 1'b0;
            else if (k < 40) exp_tx = w[k/8 - 1];
            else             exp_tx = 1'b1;
            check($sformatf("%s tx k=%0d", tag, k), a_tx, exp_tx);
            check($sformatf("%s busy k=%0d", tag, k), a_busy, 1'b1);
            check($sformatf("%s done k=%0d", tag, k), a_done, (k == 47));
            check($sformatf("%s ren k=%0d", tag, k), a_ren, 1'b0);
            if (k == push_k) push_a(push_w);
        end
    endtask

    logic exp_b [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_i = 1'b0;

        // 1: asynchronous reset between edges, FIFO empty
        #2 rst_i = 1'b1;
        #1;
        check("rst tx", a_tx, 1'b1);
        check("rst busy", a_busy, 1'b0);
        check("rst done", a_done, 1'b0);
        check("rst ren", a_ren, 1'b0);
        check("rst b tx", b_tx, 1'b1);
        check("rst b busy", b_busy, 1'b0);
        repeat (3) begin
            @(negedge rclk);
            check("rst hold tx", a_tx, 1'b1);
            check("rst hold busy", a_busy, 1'b0);
            check("rst hold ren", a_ren, 1'b0);
        end
        @(negedge rclk);
        rst_i = 1'b0;
        @(negedge rclk);
        idle_a("post rst", 1'b0);

        // 2: single word 4'hA -> 0,0,1,0,1,1
        @(negedge rclk);
        push_a(4'hA);
        #1 check("t2 ren", a_ren, 1'b1);
        frame_a(4'hA, -1, 4'h0, "t2");
        @(negedge rclk);
        idle_a("t2 end", 1'b0);

        // 3: back-to-back 4'h5, 4'hF; second pop 49 clocks after the first
        @(negedge rclk);
        push_a(4'h5);
        push_a(4'hF);
        #1 check("t3 ren0", a_ren, 1'b1);
        frame_a(4'h5, -1, 4'h0, "t3a");
        @(negedge rclk);
        idle_a("t3 gap", 1'b1);
        frame_a(4'hF, -1, 4'h0, "t3b");
        @(negedge rclk);
        idle_a("t3 end", 1'b0);

        // 4: word arrives during DATA of the previous frame
        @(negedge rclk);
        push_a(4'hC);
        #1 check("t4 ren0", a_ren, 1'b1);
        frame_a(4'hC, 20, 4'h3, "t4a");
        @(negedge rclk);
        idle_a("t4 gap", 1'b1);
        frame_a(4'h3, -1, 4'h0, "t4b");
        @(negedge rclk);
        idle_a("t4 end", 1'b0);

        // 5: reset during data bit 2 of 4'h9
        @(negedge rclk);
        push_a(4'h9);
        #1 check("t5 ren", a_ren, 1'b1);
        for (int k = 0; k <= 26; k++) @(negedge rclk);
        check("t5 bit2", a_tx, 1'b0);
        check("t5 busy pre", a_busy, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("t5 rst tx", a_tx, 1'b1);
        check("t5 rst busy", a_busy, 1'b0);
        check("t5 rst done", a_done, 1'b0);
        check("t5 rst ren", a_ren, 1'b0);
        @(negedge rclk);
        rst_i = 1'b0;
        repeat (20) begin
            @(negedge rclk);
            check("t5 post tx", a_tx, 1'b1);
            check("t5 post busy", a_busy, 1'b0);
            check("t5 post ren", a_ren, 1'b0);
        end

        // 6: DW=1, DIV=2 stream 1,0
        @(negedge rclk);
        push_b(1'b1);
        push_b(1'b0);
        #1 check("t6 ren0", b_ren, 1'b1);
        for (int k = 0; k < 13; k++) begin
            @(negedge rclk);
            check($sformatf("t6 tx k=%0d", k), b_tx, exp_b[k]);
            check($sformatf("t6 ren k=%0d", k), b_ren, (k == 6));
            check($sformatf("t6 done k=%0d", k), b_done, (k == 5 || k == 12));
            check($sformatf("t6 busy k=%0d", k), b_busy, (k != 6));
        end
        @(negedge rclk);
        check("t6 end tx", b_tx, 1'b1);
        check("t6 end busy", b_busy, 1'b0);
        check("t6 end ren", b_ren, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
